pc_sequencer: RTL and testbench

Fetch/PC sequencing controller for the single-cycle RISC-V core. It drives the next-PC input of the program counter register, runs the instruction-memory fetch handshake, and arbitrates PC redirects from branches and jumps, traps and `mret`. It sits between the PC register, instruction memory and the execute/branch logic, and turns the free-running PC into a sequenced fetch/execute loop with stall and trap support.

---
 rtl/rv_core_pkg.sv | 28 ++
 rtl/fetch_timeout_counter.sv | 35 +++
 rtl/pc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared definitions for the single-cycle RISC-V core front end.
// Provides the PC sequencer state encoding, trap cause codes and the
// sequential PC increment.
package rv_core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } pcseq_state_t;

    localparam logic [CAUSE_W-1:0] CAUSE_INSTR_MISALIGNED   = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR      = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M            = 4'd11;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-acknowledged fetch cycles.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset, clears the count
//   clear   - clears the count (ack received or not fetching)
//   enable  - count one more waiting cycle
//   expired - count has reached FETCH_TIMEOUT-1 (last allowed waiting cycle)
module fetch_timeout_counter #(
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(FETCH_TIMEOUT) + 1;

    logic [CNT_W-1:0] r_count;

    // Saturates at the expiry value; the sequencer leaves FETCH at that point.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == CNT_W'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/PC sequencing controller: drives the PC register's next value, runs
// the instruction-memory fetch handshake and arbitrates redirects, traps and
// mret.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   pc_cur / pc_next           - PC register output / PC register next value
//   imem_req/addr/ack/rdata    - instruction fetch handshake
//   instr, instr_valid         - latched instruction and execute qualifier
//   stall                      - hold the executing instruction
//   redirect_valid/target      - taken branch or jump
//   trap_req, trap_cause       - synchronous exception from execute
//   mret                       - return from trap
//   mepc, mcause               - saved trap PC and cause
module pc_sequencer
    import rv_core_pkg::*;
#(
    parameter logic [31:0]  RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0]  TRAP_VECTOR   = 32'h0000_0100,
    parameter int unsigned  FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap_req,
    input  logic [3:0]  trap_cause,
    input  logic        mret,
    output logic [31:0] mepc,
    output logic [3:0]  mcause
);

    pcseq_state_t r_state;
    pcseq_state_t w_state_next;

    logic [31:0] r_instr;
    logic [31:0] r_mepc;
    logic [3:0]  r_mcause;

    logic [31:0] w_pc_next;
    logic        w_imem_req;
    logic        w_instr_valid;
    logic        w_instr_load;
    logic        w_trap_take;
    logic [3:0]  w_trap_cause;

    logic        w_cnt_clear;
    logic        w_cnt_enable;
    logic        w_expired;

    // Counter only runs while waiting in FETCH; any ack or other state clears it.
    assign w_cnt_clear  = (r_state != S_FETCH) || imem_ack;
    assign w_cnt_enable = (r_state == S_FETCH);

    fetch_timeout_counter #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_timeout_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, next-PC and handshake decode.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = pc_cur;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        w_instr_load  = 1'b0;
        w_trap_take   = 1'b0;
        w_trap_cause  = '0;

        case (r_state)
            S_RESET: begin
                w_pc_next    = RESET_VECTOR;
                w_state_next = S_FETCH;
            end

            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_instr_load = 1'b1;
                    w_state_next = S_EXEC;
                end else if (w_expired) begin
                    w_trap_take  = 1'b1;
                    w_trap_cause = CAUSE_INSTR_ACCESS_FAULT;
                    w_state_next = S_TRAP;
                end
            end

            S_EXEC: begin
                w_instr_valid = 1'b1;
                // Fixed priority: exception, misaligned redirect, mret,
                // redirect, stall, sequential.
                if (trap_req) begin
                    w_trap_take  = 1'b1;
                    w_trap_cause = trap_cause;
                    w_state_next = S_TRAP;
                end else if (redirect_valid && is_misaligned(redirect_target)) begin
                    w_trap_take  = 1'b1;
                    w_trap_cause = CAUSE_INSTR_MISALIGNED;
                    w_state_next = S_TRAP;
                end else if (mret) begin
                    w_pc_next    = r_mepc;
                    w_state_next = S_FETCH;
                end else if (redirect_valid) begin
                    w_pc_next    = redirect_target;
                    w_state_next = S_FETCH;
                end else if (stall) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_pc_next    = pc_cur + PC_STEP;
                    w_state_next = S_FETCH;
                end
            end

            S_TRAP: begin
                w_pc_next    = TRAP_VECTOR;
                w_state_next = S_FETCH;
            end

            default: begin
                w_pc_next    = RESET_VECTOR;
                w_state_next = S_RESET;
            end
        endcase
    end

    // Instruction latch and trap CSR capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr  <= '0;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            if (w_instr_load) begin
                r_instr <= imem_rdata;
            end
            if (w_trap_take) begin
                r_mepc   <= pc_cur;
                r_mcause <= w_trap_cause;
            end
        end
    end

    assign pc_next     = w_pc_next;
    assign imem_req    = w_imem_req;
    assign imem_addr   = pc_cur;
    assign instr       = r_instr;
    assign instr_valid = w_instr_valid;
    assign mepc        = r_mepc;
    assign mcause      = r_mcause;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a PC register model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic [3:0]  trap_cause;
    logic        mret;
    logic [31:0] mepc;
    logic [3:0]  mcause;

    logic [31:0] pc_reg = 32'h0;
    logic        force_en = 1'b0;
    logic [31:0] force_pc = 32'h0;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .RESET_VECTOR  (32'h0000_0000),
        .TRAP_VECTOR   (32'h0000_0100),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .trap_cause      (trap_cause),
        .mret            (mret),
        .mepc            (mepc),
        .mcause          (mcause)
    );

    always #5 clk = ~clk;

    // PC register: loads pc_next every clock, resets to the reset vector.
    always @(posedge clk) begin
        if (reset) pc_reg <= 32'h0;
        else       pc_reg <= pc_next;
    end

    assign pc_cur = force_en ? force_pc : pc_reg;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle fetch with data returned in the current FETCH cycle.
    task automatic fetch_ok(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next got=%h exp=00000000", pc_next); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        checks++; if (mepc !== 32'h0 || mcause !== 4'h0) begin errors++; $display("FAIL reset_csr got=%h/%h exp=0/0", mepc, mcause); end
        reset = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_fetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL fetch_hold got=%h exp=00000000", pc_next); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i) * 32'd4;
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL seq_fetch%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, exp_pc); end
            fetch_ok(32'h0000_1000 + 32'(i));
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_1000 + 32'(i)) begin errors++; $display("FAIL seq_exec%0d got=%b/%h exp=1/%h", i, instr_valid, instr, 32'h0000_1000 + 32'(i)); end
            checks++; if (pc_next !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_pc_next%0d got=%h exp=%h", i, pc_next, exp_pc + 32'd4); end
            tick();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_low%0d got=%b exp=0", i, instr_valid); end
        end
    endtask

    task automatic test_redirect;
        fetch_ok(32'h0000_0013);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        #1;
        checks++; if (pc_next !== 32'h40) begin errors++; $display("FAIL redir_pc_next got=%h exp=00000040", pc_next); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_fetch got=%b/%h exp=1/00000040", imem_req, imem_addr); end
        fetch_ok(32'h0000_0033);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0042;
        tick();
        redirect_valid = 1'b0;
        // Event inputs asserted while in TRAP must not disturb the captured CSRs.
        trap_req   = 1'b1;
        trap_cause = 4'd5;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_next !== 32'h100) begin errors++; $display("FAIL misalign_trap got=%b/%b/%h exp=0/0/00000100", imem_req, instr_valid, pc_next); end
        checks++; if (mcause !== 4'd0 || mepc !== 32'h40) begin errors++; $display("FAIL misalign_csr got=%h/%h exp=0/00000040", mcause, mepc); end
        tick();
        trap_req = 1'b0;
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL misalign_vector got=%b/%h exp=1/00000100", imem_req, imem_addr); end
        checks++; if (mcause !== 4'd0 || mepc !== 32'h40) begin errors++; $display("FAIL trap_ignores_events got=%h/%h exp=0/00000040", mcause, mepc); end
    endtask

    task automatic test_stall_priority;
        fetch_ok(32'h0000_0001);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0008;
        tick();
        redirect_valid = 1'b0;
        fetch_ok(32'hCAFE_0008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_next !== 32'h8 || instr !== 32'hCAFE_0008 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall%0d got=%h/%h/%b exp=00000008/cafe0008/1", i, pc_next, instr, instr_valid); end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++; if (pc_next !== 32'hC || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%b exp=0000000c/1", pc_next, instr_valid); end
        tick();
        fetch_ok(32'h0000_0073);
        trap_req   = 1'b1;
        trap_cause = 4'd11;
        stall      = 1'b1;
        mret       = 1'b1;
        #1;
        checks++; if (pc_next !== 32'hC) begin errors++; $display("FAIL trap_prio_pc got=%h exp=0000000c", pc_next); end
        tick();
        trap_req = 1'b0;
        stall    = 1'b0;
        mret     = 1'b0;
        checks++; if (mcause !== 4'd11 || mepc !== 32'hC || pc_next !== 32'h100) begin errors++; $display("FAIL ecall_trap got=%h/%h/%h exp=b/0000000c/00000100", mcause, mepc, pc_next); end
        tick();
        fetch_ok(32'h3020_0073);
        // mret outranks an aligned redirect.
        mret            = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        #1;
        checks++; if (pc_next !== 32'hC) begin errors++; $display("FAIL mret_pc got=%h exp=0000000c", pc_next); end
        tick();
        mret           = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL mret_fetch got=%b/%h exp=1/0000000c", imem_req, imem_addr); end
    endtask

    task automatic test_fetch_timeout;
        fetch_ok(32'h0000_0001);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0020;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("FAIL timeout_still_fetching got=%b/%h exp=1/00000020", imem_req, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b0 || pc_next !== 32'h100) begin errors++; $display("FAIL timeout_trap got=%b/%h exp=0/00000100", imem_req, pc_next); end
        checks++; if (mcause !== 4'd1 || mepc !== 32'h20) begin errors++; $display("FAIL timeout_csr got=%h/%h exp=1/00000020", mcause, mepc); end
        tick();
        checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL timeout_vector got=%b/%h exp=1/00000100", imem_req, imem_addr); end
        // Ack on the last allowed cycle is accepted, proving the counter restarted.
        for (int i = 0; i < 15; i++) tick();
        fetch_ok(32'h0000_0100);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0100) begin errors++; $display("FAIL timeout_late_ack got=%b/%h exp=1/00000100", instr_valid, instr); end
        checks++; if (pc_next !== 32'h104) begin errors++; $display("FAIL timeout_late_pc got=%h exp=00000104", pc_next); end
        tick();
    endtask

    task automatic test_reset_mid_fetch;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0 || pc_next !== 32'h0 || instr !== 32'h0) begin errors++; $display("FAIL midreset got=%b/%h/%h exp=0/00000000/00000000", imem_req, pc_next, instr); end
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_late_ack got=%h/%b exp=00000000/0", instr, instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL midreset_refetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        // Counter must have cleared: 15 waits then ack still executes.
        for (int i = 0; i < 15; i++) tick();
        fetch_ok(32'h0000_0093);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0093) begin errors++; $display("FAIL midreset_counter got=%b/%h exp=1/00000093", instr_valid, instr); end
    endtask

    task automatic test_wrap;
        force_en = 1'b1;
        force_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_next !== 32'h0 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap got=%h/%h exp=00000000/fffffffc", pc_next, imem_addr); end
        tick();
        force_en = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_fetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

    initial begin
        reset           = 1'b1;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_req        = 1'b0;
        trap_cause      = 4'h0;
        mret            = 1'b0;

        test_reset();
        test_sequential();
        test_redirect();
        test_stall_priority();
        test_fetch_timeout();
        test_reset_mid_fetch();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
